// File: rtl/pc_sequencer_pkg.sv
// Shared definitions for the program sequencer: instruction opcodes
// and the sequencer state encoding.
package pc_sequencer_pkg;

    // Opcodes in instruction bits [15:12]
    localparam logic [3:0] OP_COMP  = 4'h5;
    localparam logic [3:0] OP_CHECK = 4'h6;
    localparam logic [3:0] OP_JMP   = 4'hA;
    localparam logic [3:0] OP_JNO   = 4'hB;
    localparam logic [3:0] OP_JNZ   = 4'hC;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_ISSUE     = 3'd3,
        ST_WAIT_DONE = 3'd4,
        ST_HALT      = 3'd5,
        ST_ABORT     = 3'd6
    } seq_state_e;

    // True for instructions whose completion updates the compare flag
    function automatic logic is_flag_op(input logic [3:0] opcode);
        return (opcode == OP_COMP) || (opcode == OP_CHECK);
    endfunction

endpackage

// File: rtl/pc_sequencer_branch.sv
// Combinational branch resolution: picks the next PC for the instruction
// held in the IR and flags branches and the self-jump halt idiom.
// For non-branch opcodes next_pc is the sequential successor.
module seq_branch_unit
    import pc_sequencer_pkg::*;
(
    input  logic [3:0] opcode_i,
    input  logic [7:0] target_i,
    input  logic [7:0] pc_i,
    input  logic       flag_eq_i,
    output logic [7:0] next_pc_o,
    output logic       is_branch_o,
    output logic       is_halt_o
);

    logic [7:0] seq_pc_s;

    assign seq_pc_s = pc_i + 8'd1;

    // Decode the opcode into a next-PC choice and branch/halt indications
    always_comb begin
        next_pc_o   = seq_pc_s;
        is_branch_o = 1'b0;
        is_halt_o   = 1'b0;
        case (opcode_i)
            OP_JMP: begin
                is_branch_o = 1'b1;
                if (target_i == pc_i) begin
                    is_halt_o = 1'b1;
                    next_pc_o = pc_i;
                end else begin
                    next_pc_o = target_i;
                end
            end
            OP_JNO: begin
                is_branch_o = 1'b1;
                next_pc_o   = flag_eq_i ? seq_pc_s : target_i;
            end
            OP_JNZ: begin
                is_branch_o = 1'b1;
                next_pc_o   = flag_eq_i ? target_i : seq_pc_s;
            end
            default: begin
                is_branch_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Program sequencer: owns the PC, resolves branches locally and hands all
// other instructions to the datapath via valid/ready plus a done pulse.
// Stops on a self-jump (halt) or when the retire budget is exhausted (abort).
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter logic [7:0] RESET_PC  = 8'd0,
    parameter int         STEP_W    = 16,
    parameter int         MAX_STEPS = 4000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [7:0]        pc,
    input  logic [15:0]       op,
    output logic              ex_valid,
    output logic [15:0]       ex_op,
    input  logic              ex_ready,
    input  logic              ex_done,
    input  logic              ex_flag_eq,
    output logic              busy,
    output logic              halted,
    output logic              aborted,
    output logic [STEP_W-1:0] step_count
);

    localparam logic BUDGET_EN_C = (MAX_STEPS != 0);

    seq_state_e        state_q, state_d;
    logic [7:0]        pc_q, pc_d;
    logic [15:0]       ir_q, ir_d;
    logic              flag_eq_q, flag_eq_d;
    logic              ex_valid_q, ex_valid_d;
    logic [15:0]       ex_op_q, ex_op_d;
    logic              busy_q, busy_d;
    logic              halted_q, halted_d;
    logic              aborted_q, aborted_d;
    logic [STEP_W-1:0] step_q, step_d;

    logic [7:0]        next_pc_s;
    logic              is_branch_s;
    logic              is_halt_s;
    logic [STEP_W-1:0] step_sat_s;
    logic              budget_hit_s;

    seq_branch_unit u_branch (
        .opcode_i    (ir_q[15:12]),
        .target_i    (ir_q[7:0]),
        .pc_i        (pc_q),
        .flag_eq_i   (flag_eq_q),
        .next_pc_o   (next_pc_s),
        .is_branch_o (is_branch_s),
        .is_halt_o   (is_halt_s)
    );

    // Retire count after one more instruction, held at all-ones once full
    assign step_sat_s   = (&step_q) ? step_q : (step_q + {{(STEP_W-1){1'b0}}, 1'b1});
    assign budget_hit_s = BUDGET_EN_C && (step_sat_s == STEP_W'(MAX_STEPS));

    // Next-state and next-output computation for the sequencer FSM
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        flag_eq_d  = flag_eq_q;
        ex_valid_d = ex_valid_q;
        ex_op_d    = ex_op_q;
        halted_d   = halted_q;
        aborted_d  = aborted_q;
        step_d     = step_q;
        case (state_q)
            ST_IDLE, ST_HALT, ST_ABORT: begin
                if (start) begin
                    state_d   = ST_FETCH;
                    pc_d      = RESET_PC;
                    step_d    = {STEP_W{1'b0}};
                    halted_d  = 1'b0;
                    aborted_d = 1'b0;
                    flag_eq_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_FETCH: begin
                ir_d    = op;
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_branch_s) begin
                    // Branches retire here; halt takes priority over the budget
                    step_d = step_sat_s;
                    pc_d   = next_pc_s;
                    if (is_halt_s) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end else if (budget_hit_s) begin
                        state_d   = ST_ABORT;
                        aborted_d = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    ex_op_d    = ir_q;
                    ex_valid_d = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ex_ready) begin
                    ex_valid_d = 1'b0;
                    state_d    = ST_WAIT_DONE;
                end else begin
                    ex_valid_d = 1'b1;
                end
            end
            ST_WAIT_DONE: begin
                if (ex_done) begin
                    if (is_flag_op(ir_q[15:12])) begin
                        flag_eq_d = ex_flag_eq;
                    end else begin
                        flag_eq_d = flag_eq_q;
                    end
                    pc_d   = next_pc_s;
                    step_d = step_sat_s;
                    if (budget_hit_s) begin
                        state_d   = ST_ABORT;
                        aborted_d = 1'b1;
                    end else begin
                        state_d = ST_FETCH;
                    end
                end else begin
                    state_d = ST_WAIT_DONE;
                end
            end
            default: begin
                // Unreachable encodings recover to a quiet idle
                state_d    = ST_IDLE;
                ex_valid_d = 1'b0;
            end
        endcase
        busy_d = !((state_d == ST_IDLE) || (state_d == ST_HALT) || (state_d == ST_ABORT));
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pc_q       <= RESET_PC;
            ir_q       <= 16'h0000;
            flag_eq_q  <= 1'b0;
            ex_valid_q <= 1'b0;
            ex_op_q    <= 16'h0000;
            busy_q     <= 1'b0;
            halted_q   <= 1'b0;
            aborted_q  <= 1'b0;
            step_q     <= {STEP_W{1'b0}};
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            flag_eq_q  <= flag_eq_d;
            ex_valid_q <= ex_valid_d;
            ex_op_q    <= ex_op_d;
            busy_q     <= busy_d;
            halted_q   <= halted_d;
            aborted_q  <= aborted_d;
            step_q     <= step_d;
        end
    end

    assign pc         = pc_q;
    assign ex_valid   = ex_valid_q;
    assign ex_op      = ex_op_q;
    assign busy       = busy_q;
    assign halted     = halted_q;
    assign aborted    = aborted_q;
    assign step_count = step_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: an instruction-level interpreter predicts
// the issued (pc, instruction) stream and the final halt/abort outcome; a
// monitor pops expectations at each ex_valid/ex_ready handshake.
module tb_pc_sequencer;
    import pc_sequencer_pkg::*;

    localparam int TB_MAX = 24;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  pc;
    logic [15:0] op;
    logic        ex_valid;
    logic [15:0] ex_op;
    logic        ex_ready;
    logic        ex_done;
    logic        ex_flag_eq;
    logic        busy;
    logic        halted;
    logic        aborted;
    logic [15:0] step_count;

    logic [15:0] imem [256];

    assign op = imem[pc];

    always #5 clk = ~clk;

    pc_sequencer #(.RESET_PC(8'd0), .STEP_W(16), .MAX_STEPS(TB_MAX)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pc(pc), .op(op),
        .ex_valid(ex_valid), .ex_op(ex_op), .ex_ready(ex_ready),
        .ex_done(ex_done), .ex_flag_eq(ex_flag_eq), .busy(busy),
        .halted(halted), .aborted(aborted), .step_count(step_count)
    );

    typedef struct packed {
        logic [7:0]  pc;
        logic [15:0] op;
    } issue_t;

    int     checks = 0;
    int     passes = 0;
    issue_t exp_q[$];
    bit     flags[$];
    bit     exp_halt;
    bit     exp_abort;
    int     exp_pc;
    int     exp_steps;
    int     exp_cycles;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    endtask

    // Instruction-level interpreter of the program in imem
    task automatic model_run();
        int p, steps, cyc, fi, tgt;
        bit f;
        logic [15:0] w;
        logic [3:0]  o;
        p = 0; steps = 0; cyc = 1; fi = 0; f = 1'b0;
        exp_q.delete();
        exp_halt = 1'b0;
        exp_abort = 1'b0;
        while (1) begin
            w = imem[p];
            o = w[15:12];
            tgt = int'(w[7:0]);
            steps++;
            if (o == OP_JMP || o == OP_JNO || o == OP_JNZ) begin
                cyc += 2;
                if (o == OP_JMP && tgt == p) begin
                    exp_halt = 1'b1;
                    break;
                end
                if (o == OP_JMP) p = tgt;
                else if (o == OP_JNO) p = f ? (p + 1) % 256 : tgt;
                else p = f ? tgt : (p + 1) % 256;
            end else begin
                exp_q.push_back('{pc: 8'(p), op: w});
                if (o == OP_COMP || o == OP_CHECK) f = flags[fi];
                fi++;
                cyc += 4;
                p = (p + 1) % 256;
            end
            if (steps == TB_MAX) begin
                exp_abort = 1'b1;
                break;
            end
        end
        exp_pc = p;
        exp_steps = steps;
        exp_cycles = cyc;
    endtask

    task automatic random_flags();
        flags.delete();
        for (int i = 0; i < TB_MAX; i++) flags.push_back(1'($urandom));
    endtask

    task automatic clear_imem();
        for (int a = 0; a < 256; a++) imem[a] = 16'h0000;
    endtask

    task automatic gen_random();
        int r;
        for (int a = 0; a < 256; a++) begin
            r = $urandom_range(0, 19);
            if (r < 3)       imem[a] = {OP_JMP, 4'($urandom), 8'($urandom)};
            else if (r == 3) imem[a] = {OP_JMP, 4'h0, 8'(a)};
            else if (r < 6)  imem[a] = {OP_JNO, 4'($urandom), 8'($urandom)};
            else if (r < 9)  imem[a] = {OP_JNZ, 4'($urandom), 8'($urandom)};
            else if (r < 12) imem[a] = {OP_COMP, 12'($urandom)};
            else if (r < 14) imem[a] = {OP_CHECK, 12'($urandom)};
            else             imem[a] = {4'($urandom_range(0, 9)), 12'($urandom)};
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_pc"}, pc, 0);
        check({tag, "_ex_valid"}, ex_valid, 0);
        check({tag, "_ex_op"}, ex_op, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_halted"}, halted, 0);
        check({tag, "_aborted"}, aborted, 0);
        check({tag, "_step"}, step_count, 0);
    endtask

    // Start a run and act as the datapath until the DUT halts or aborts
    task automatic run_prog(input string name, input bit fast);
        int  k, fi, dcnt;
        bit  pending, rdy_given, done;
        model_run();
        k = 0; fi = 0; dcnt = 0; pending = 0; rdy_given = 0; done = 0;
        @(negedge clk);
        start = 1'b1; ex_ready = 1'b0; ex_done = 1'b0;
        while (!done && k < 3000) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                check({name, "_start_pc"}, pc, 0);
                check({name, "_start_flags"}, {halted, aborted, busy}, 3'b001);
            end
            if (halted || aborted) begin
                done = 1'b1;
            end else begin
                start = 1'b0; ex_ready = 1'b0; ex_done = 1'b0;
                ex_flag_eq = 1'($urandom);
                if (rdy_given) begin
                    pending = 1'b1;
                    rdy_given = 1'b0;
                    dcnt = fast ? 0 : $urandom_range(0, 3);
                end
                if (pending) begin
                    if (dcnt == 0) begin
                        ex_done = 1'b1;
                        ex_flag_eq = (fi < flags.size()) ? flags[fi] : 1'b0;
                        fi++;
                        pending = 1'b0;
                    end else begin
                        dcnt--;
                    end
                end else if (ex_valid) begin
                    if (fast || $urandom_range(0, 2) == 0) begin
                        ex_ready = 1'b1;
                        rdy_given = 1'b1;
                    end else if ($urandom_range(0, 2) == 0) begin
                        ex_done = 1'b1;
                    end else if ($urandom_range(0, 2) == 0) begin
                        start = 1'b1;
                    end
                end
            end
        end
        start = 1'b0; ex_ready = 1'b0; ex_done = 1'b0;
        check({name, "_timeout"}, done, 1);
        check({name, "_halted"}, halted, exp_halt);
        check({name, "_aborted"}, aborted, exp_abort);
        check({name, "_pc"}, pc, exp_pc);
        check({name, "_steps"}, step_count, exp_steps);
        check({name, "_busy"}, busy, 0);
        check({name, "_issues_left"}, exp_q.size(), 0);
        if (fast) check({name, "_cycles"}, k, exp_cycles);
        repeat (3) @(negedge clk);
        check({name, "_pc_hold"}, pc, exp_pc);
        check({name, "_state_hold"}, {halted, aborted}, {exp_halt, exp_abort});
    endtask

    // Monitor: compare each accepted issue against the scoreboard and
    // require ex_op to stay stable while ex_valid is held
    initial begin
        issue_t      e;
        logic [15:0] prev_op;
        bit          prev_v;
        prev_v = 1'b0;
        prev_op = 16'h0000;
        forever begin
            @(negedge clk);
            #2;
            if (rst_n && ex_valid && prev_v) check("ex_op_stable", ex_op, prev_op);
            if (rst_n && ex_valid && ex_ready) begin
                if (exp_q.size() == 0) begin
                    check("issue_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("issue_pc", pc, e.pc);
                    check("issue_op", ex_op, e.op);
                end
            end
            prev_v = rst_n && ex_valid && !ex_ready;
            prev_op = ex_op;
        end
    end

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; ex_ready = 1'b0; ex_done = 1'b0; ex_flag_eq = 1'b0;
        clear_imem();
        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // COMP then JNO taken on flag 0
        clear_imem();
        imem[0] = {OP_COMP, 12'h123};
        imem[1] = {OP_JNO, 4'h0, 8'd6};
        imem[6] = {OP_JMP, 4'h0, 8'd6};
        flags.delete(); flags.push_back(1'b0);
        run_prog("jno_taken", 1'b1);

        // COMP sets flag 1; JNO falls through, JNZ taken
        clear_imem();
        imem[0]  = {OP_COMP, 12'h456};
        imem[1]  = {OP_JNO, 4'h0, 8'd6};
        imem[2]  = {OP_JNZ, 4'h0, 8'd77};
        imem[6]  = {OP_JMP, 4'h0, 8'd6};
        imem[77] = {OP_JMP, 4'h0, 8'd77};
        flags.delete(); flags.push_back(1'b1);
        run_prog("jnz_taken", 1'b1);

        // Reset while an instruction is being offered
        clear_imem();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n = 0;
        while (!ex_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midrst_reach_issue", ex_valid, 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrst");
        @(posedge clk);
        #1;
        check("midrst_next_valid", ex_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ping-pong jumps run into the budget
        clear_imem();
        imem[0] = {OP_JMP, 4'h0, 8'd1};
        imem[1] = {OP_JMP, 4'h0, 8'd0};
        random_flags();
        run_prog("budget_abort", 1'b1);

        // Self-jump landing exactly on the budget step halts
        clear_imem();
        for (int a = 0; a < TB_MAX - 1; a++) imem[a] = {OP_COMP, 12'(a)};
        imem[TB_MAX - 1] = {OP_JMP, 4'h0, 8'(TB_MAX - 1)};
        random_flags();
        run_prog("halt_on_budget", 1'b1);

        // Non-branch at 255 wraps to 0
        clear_imem();
        imem[0]   = {OP_JMP, 4'h0, 8'd255};
        imem[255] = {OP_CHECK, 12'hABC};
        random_flags();
        run_prog("pc_wrap", 1'b1);

        // Random programs with random handshake timing
        for (int t = 0; t < 20; t++) begin
            gen_random();
            random_flags();
            run_prog($sformatf("rand%0d", t), 1'b0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
